ro_freq_meter: RTL and testbench
================================

Name: ro_freq_meter

Overview:
- Measurement end of the ring-oscillator path: drives a ring's enable and samples its free-running output.
- Counts the ring's rising edges over a fixed window of system-clock cycles.
- Returns the count through a valid/ready result interface, for characterising ring frequency per enable and per chain length.
- One instance per ring; the ring output is asynchronous to clk.

Parameters:
- GATE_CYCLES, 1000: length of the counting window in clk cycles (>=1).
- SETTLE_CYCLES, 16: clk cycles between enabling the ring and opening the window (>=1).
- CNT_W, 16: width of the result counter.
- SYNC_STAGES, 2: flip-flop depth of the ro_in synchroniser (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a measurement; honoured only in IDLE.
- ro_in  in  1  ring-oscillator output, asynchronous to clk.
- ro_en  out  1  ring enable, driven to the ring's en input.
- busy  out  1  high in every state except IDLE.
- result  out  CNT_W  rising-edge count for the last window.
- overflow  out  1  count saturated during the last window.
- result_valid  out  1  result/overflow available.
- result_ready  in  1  consumer accepts result.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-low (rst_n sampled on clk rising edge).
  - While rst_n=0: state=IDLE, ro_en=0, busy=0, result=0, overflow=0, result_valid=0, all counters 0, synchroniser and edge-detect flops 0.
  - Reset asserted in any state aborts the measurement and drops ro_en on that same edge.
- Synchroniser: ro_in passes through SYNC_STAGES flops (s_last), then one delay flop (s_prev); rise = s_last & ~s_prev. Edge latency from ro_in is SYNC_STAGES+1 clk cycles.
- FSM states: IDLE, SETTLE, GATE, HOLD.
- IDLE:
  - ro_en=0.
  - start=1 -> SETTLE next cycle; cnt cleared, overflow cleared, timer loaded.
- SETTLE:
  - ro_en=1, from the first SETTLE cycle onward.
  - Stays exactly SETTLE_CYCLES cycles; no counting.
  - Then -> GATE.
- GATE:
  - ro_en=1.
  - Stays exactly GATE_CYCLES cycles; each cycle with rise=1 increments cnt.
  - At cnt = 2^CNT_W-1, a further rise holds cnt and sets overflow sticky.
  - After the last GATE cycle -> HOLD. Edges still inside the synchroniser at window close are discarded.
- HOLD:
  - ro_en=0, result_valid=1; result=cnt and overflow stay stable until accepted.
  - result_valid & result_ready -> IDLE next cycle, result_valid=0. result and overflow keep their values until the next start.
  - result_ready while result_valid=0 has no effect.
- Timing: with start sampled at cycle 0, ro_en rises at cycle 1 and result_valid rises at cycle 1+SETTLE_CYCLES+GATE_CYCLES.
- start outside IDLE is ignored, including the handshake cycle in HOLD. start in the cycle after the handshake is honoured.
- The synchroniser runs in all states. The edge-detect history is not cleared at GATE entry, so a level already high gives no spurious edge.
- The timer is wide enough for max(SETTLE_CYCLES, GATE_CYCLES). The timer and cnt use no wrap-around arithmetic.

Test Plan:
- Bench toggles ro_in every 5 clk (period 10); GATE_CYCLES=1000, SETTLE_CYCLES=16; pulse start -> result_valid exactly 1017 cycles after start sample, result in {99,100,101}, overflow=0.
- ro_in held 0, then held 1 across a run -> result=0 both times, overflow=0; ro_en high only during SETTLE+GATE.
- CNT_W=4, ro_in period 4 clk, GATE_CYCLES=100 -> result=15, overflow=1.
- Backpressure: result_ready low for 50 cycles after valid -> result_valid, result and overflow stable throughout; one cycle after ready=1, result_valid=0 and busy=0; start pulses during the run and in the handshake cycle produce no new measurement.
- rst_n=0 for one cycle mid-GATE -> next cycle ro_en=0, busy=0, result=0, result_valid=0; a subsequent start gives a correct full-length measurement.
- Back-to-back: start in the cycle after the handshake -> second run begins (ro_en=1 next cycle) and returns the same count ±1 for an unchanged ro_in period.

Source files
------------

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables a ring, lets it settle, then
// counts synchronised rising edges of its output over a fixed clk window.
module ro_freq_meter #(
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ?
                        GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] GATE   = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [TW-1:0]    T_SETTLE = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    T_GATE   = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]             state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   en_q, en_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  // Edge history runs in every state so a steady level never looks like an edge.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          timer_d = T_SETTLE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          state_d = GATE;
          timer_d = T_GATE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      GATE: begin
        if (rise) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_W'(1);
        end
        if (timer_q == '0) state_d = HOLD;
        else               timer_d = timer_q - TW'(1);
      end
      HOLD: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    en_d = (state_d == SETTLE) || (state_d == GATE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b0;
      sync_q  <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ro_in};
      prev_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ro_en        = en_q;
  assign busy         = (state_q != IDLE);
  assign result       = cnt_q;
  assign overflow     = ovf_q;
  assign result_valid = (state_q == HOLD);

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: timing, counts, backpressure,
// reset abort, back-to-back runs and a narrow-counter overflow case.
module tb_ro_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n, start, ro_in, result_ready;
  logic        ro_en, busy, overflow, result_valid;
  logic [15:0] result;

  logic        start2, ro_in2, result_ready2;
  logic        ro_en2, busy2, overflow2, result_valid2;
  logic [3:0]  result2;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int ph = 0;
  int ph2 = 0;

  always #5 clk = ~clk;

  ro_freq_meter #(
    .GATE_CYCLES(1000), .SETTLE_CYCLES(16),
    .CNT_W(16), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_in(ro_in),
    .ro_en(ro_en), .busy(busy), .result(result),
    .overflow(overflow), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  ro_freq_meter #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(16),
    .CNT_W(4), .SYNC_STAGES(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .ro_in(ro_in2),
    .ro_en(ro_en2), .busy(busy2), .result(result2),
    .overflow(overflow2), .result_valid(result_valid2),
    .result_ready(result_ready2)
  );

  // mode 0: low, 1: high, 2: period 10 clk
  always @(negedge clk) begin
    case (mode)
      0: ro_in = 1'b0;
      1: ro_in = 1'b1;
      default: begin
        if (ph >= 4) begin
          ro_in = ~ro_in;
          ph = 0;
        end else begin
          ph = ph + 1;
        end
      end
    endcase
    if (ph2 >= 1) begin
      ro_in2 = ~ro_in2;
      ph2 = 0;
    end else begin
      ph2 = ph2 + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start, then steps until result_valid; n is the cycle index
  // (start sampled at cycle 0), en counts cycles with ro_en high.
  task automatic run(input int poke, output int n, output int en);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    en = ro_en ? 1 : 0;
    while (!result_valid && n < 3000) begin
      if (n == poke) start = 1'b1;
      step();
      start = 1'b0;
      n++;
      if (ro_en) en++;
    end
  endtask

  int n, en, r1, r2, stable;
  logic [15:0] hold_res;
  logic        hold_ovf;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ro_in = 1'b0;
    result_ready = 1'b0;
    start2 = 1'b0;
    ro_in2 = 1'b0;
    result_ready2 = 1'b0;
    step();
    step();
    chk("rst_ro_en", 32'(ro_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_valid", 32'(result_valid), 0);
    rst_n = 1'b1;
    mode = 2;
    repeat (20) step();

    // Run 1: timing, count, start ignored mid-run, backpressure
    run(500, n, en);
    chk("r1_latency", 32'(n), 1017);
    chk("r1_en_cycles", 32'(en), 1016);
    chk("r1_ro_en_hold", 32'(ro_en), 0);
    chk("r1_range", 32'(result >= 99 && result <= 101), 1);
    chk("r1_ovf", 32'(overflow), 0);
    r1 = int'(result);
    hold_res = result;
    hold_ovf = overflow;
    stable = 1;
    repeat (50) begin
      step();
      if (!result_valid || result !== hold_res ||
          overflow !== hold_ovf || !busy) stable = 0;
    end
    chk("bp_stable", 32'(stable), 1);
    result_ready = 1'b1;
    start = 1'b1;
    step();
    result_ready = 1'b0;
    start = 1'b0;
    chk("hs_valid", 32'(result_valid), 0);
    chk("hs_busy", 32'(busy), 0);
    chk("hs_result_kept", 32'(result), 32'(hold_res));
    step();
    step();
    chk("hs_start_ignored", 32'(busy), 0);

    // Run 2: back-to-back with start right after the handshake
    run(0, n, en);
    chk("r2_latency", 32'(n), 1017);
    r2 = int'(result);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_ro_en", 32'(ro_en), 1);
    chk("b2b_busy", 32'(busy), 1);
    n = 1;
    while (!result_valid && n < 3000) begin
      step();
      n++;
    end
    chk("b2b_latency", 32'(n), 1017);
    chk("b2b_same", 32'(result >= r2 - 1 && result <= r2 + 1), 1);
    chk("r1_r2_same", 32'(r2 >= r1 - 1 && r2 <= r1 + 1), 1);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;

    // Static levels give no edges
    mode = 0;
    repeat (10) step();
    run(0, n, en);
    chk("low_result", 32'(result), 0);
    chk("low_ovf", 32'(overflow), 0);
    chk("low_en", 32'(en), 1016);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    mode = 1;
    repeat (10) step();
    run(0, n, en);
    chk("high_result", 32'(result), 0);
    chk("high_ovf", 32'(overflow), 0);
    chk("high_en", 32'(en), 1016);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;

    // Reset mid-GATE then full-length rerun
    mode = 2;
    repeat (10) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (300) step();
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("arst_ro_en", 32'(ro_en), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_result", 32'(result), 0);
    chk("arst_valid", 32'(result_valid), 0);
    repeat (5) step();
    run(0, n, en);
    chk("post_rst_latency", 32'(n), 1017);
    chk("post_rst_range", 32'(result >= 99 && result <= 101), 1);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;

    // Narrow counter saturates: 25 edges into 4 bits
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    n = 1;
    while (!result_valid2 && n < 1000) begin
      step();
      n++;
    end
    chk("ovf_latency", 32'(n), 117);
    chk("ovf_result", 32'(result2), 15);
    chk("ovf_flag", 32'(overflow2), 1);
    result_ready2 = 1'b1;
    step();
    result_ready2 = 1'b0;
    chk("ovf_idle", 32'(busy2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
